umi_mux_rr: RTL and testbench

UMI_MUX_RR -- requirements
Module: umi_mux_rr

---
 rtl/umi_pkg.sv | 18 +
 rtl/umi_arbiter.sv | 25 ++
 rtl/umi_mux_rr.sv | 116 +++++++++++
 tb/tb_umi_mux_rr.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_pkg.sv
// Shared UMI definitions: arbitration mode encodings and a mode decode helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package umi_pkg;

    typedef enum logic [1:0] {
        UMI_ARB_FIXED = 2'b00,
        UMI_ARB_RR    = 2'b01,
        UMI_ARB_RSVD2 = 2'b10,
        UMI_ARB_RSVD3 = 2'b11
    } umi_arbmode_e;

    // Reserved encodings fall back to round-robin.
    function automatic logic umi_arb_is_rr(input logic [1:0] mode);
        return mode != UMI_ARB_FIXED;
    endfunction

endpackage

// File: rtl/umi_arbiter.sv
// N-way grant generator: rotate requests by base, pick lowest, rotate back.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
module umi_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] base,
    output logic [N-1:0]  grant
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] rot;
    logic [N-1:0] pgrant;

    // Doubling the vector turns a rotate into a plain shift; base is always < N.
    always_comb begin
        rot    = N'({req, req} >> base);
        pgrant = rot & (~rot + ONE);
        grant  = N'(({pgrant, pgrant} << base) >> N);
    end

endmodule

// File: rtl/umi_mux_rr.sv
// N:1 UMI mux with fixed-priority / round-robin arbitration and stall lock.
// Latency: zero cycles, a valid candidate appears on umi_out the same cycle.
// Backpressure: stalled grant is locked until it handshakes; ready goes only to the grantee.
module umi_mux_rr
    import umi_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 128
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [1:0]      arbmode,
    input  logic [N-1:0]    arbmask,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic          lock_q;
    logic [N-1:0]  lock_grant_q;

    logic [N-1:0]  cand;
    logic [PW-1:0] arb_base;
    logic [N-1:0]  arb_grant;
    logic          lock_hold;
    logic [N-1:0]  grant;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] ptr_next;
    logic          handshake;
    logic          stall;

    always_comb begin
        cand     = umi_in_valid & ~arbmask;
        arb_base = umi_arb_is_rr(arbmode) ? ptr_q : '0;
    end

    umi_arbiter #(
        .N  (N),
        .PW (PW)
    ) u_arbiter (
        .req   (cand),
        .base  (arb_base),
        .grant (arb_grant)
    );

    // A locked requester that drops valid releases the lock immediately so
    // the others are arbitrated in that same cycle.
    always_comb begin
        lock_hold = lock_q & |(lock_grant_q & umi_in_valid);
        if (!nreset) begin
            grant = '0;
        end else if (lock_hold) begin
            grant = lock_grant_q;
        end else begin
            grant = arb_grant;
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end
        end
        ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end

    always_comb begin
        umi_out_valid   = |grant;
        umi_in_ready    = grant & {N{umi_out_ready}};
        handshake       = umi_out_valid & umi_out_ready;
        stall           = umi_out_valid & ~umi_out_ready;
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        for (int i = 0; i < N; i++) begin
            umi_out_cmd     = umi_out_cmd     | (umi_in_cmd[i*CW +: CW]     & {CW{grant[i]}});
            umi_out_dstaddr = umi_out_dstaddr | (umi_in_dstaddr[i*AW +: AW] & {AW{grant[i]}});
            umi_out_srcaddr = umi_out_srcaddr | (umi_in_srcaddr[i*AW +: AW] & {AW{grant[i]}});
            umi_out_data    = umi_out_data    | (umi_in_data[i*DW +: DW]    & {DW{grant[i]}});
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q        <= '0;
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
        end else begin
            lock_q <= stall;
            if (stall) begin
                lock_grant_q <= grant;
            end
            if (handshake && umi_arb_is_rr(arbmode)) begin
                ptr_q <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_umi_mux_rr.sv
// Bench for umi_mux_rr: directed arbitration/lock/reset scenarios, then random
// traffic checked against a priority-list reference model and a sequence scoreboard.
module tb_umi_mux_rr;
    import umi_pkg::*;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 128;
    localparam int FW = CW + 2 * AW + DW;

    logic            clk = 1'b0;
    logic            nreset;
    logic [1:0]      arbmode;
    logic [N-1:0]    arbmask;
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready;

    logic [CW-1:0] f_cmd [N];
    logic [AW-1:0] f_dst [N];
    logic [AW-1:0] f_src [N];
    logic [DW-1:0] f_dat [N];

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_ptr  = 0;
    int m_lock = 0;
    int m_lidx = 0;
    int cur_g  = -1;

    int gen_cnt [N];
    int del_cnt [N];

    always #5 clk = ~clk;

    always_comb begin
        umi_in_cmd     = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data    = '0;
        for (int i = 0; i < N; i++) begin
            umi_in_cmd[i*CW +: CW]     = f_cmd[i];
            umi_in_dstaddr[i*AW +: AW] = f_dst[i];
            umi_in_srcaddr[i*AW +: AW] = f_src[i];
            umi_in_data[i*DW +: DW]    = f_dat[i];
        end
    end

    umi_mux_rr #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .arbmode         (arbmode),
        .arbmask         (arbmask),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready)
    );

    // Expected winner: a held lock first, else first candidate walking the
    // priority list from the start index.
    function automatic int model_grant();
        int start;
        int idx;
        if (nreset !== 1'b1) return -1;
        if (m_lock != 0 && umi_in_valid[m_lidx] === 1'b1) return m_lidx;
        start = (arbmode == UMI_ARB_FIXED) ? 0 : m_ptr;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (umi_in_valid[idx] === 1'b1 && arbmask[idx] === 1'b0) return idx;
        end
        return -1;
    endfunction

    task automatic settle_check(input string tag, input int exp_id);
        logic [N-1:0]  one;
        logic [N-1:0]  er;
        logic [FW-1:0] ef;
        logic [FW-1:0] of;
        int obs;
        #1;
        one   = 1;
        cur_g = model_grant();
        er    = (cur_g >= 0 && umi_out_ready) ? (one << cur_g) : '0;
        ef    = (cur_g >= 0) ? {f_cmd[cur_g], f_dst[cur_g], f_src[cur_g], f_dat[cur_g]} : '0;
        of    = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
        checks++;
        assert (umi_out_valid === (cur_g >= 0)) else begin
            errors++;
            $error("FAIL %s out_valid: got %b want %b", tag, umi_out_valid, cur_g >= 0);
        end
        checks++;
        assert (umi_in_ready === er) else begin
            errors++;
            $error("FAIL %s in_ready: got %b want %b", tag, umi_in_ready, er);
        end
        checks++;
        assert (of === ef) else begin
            errors++;
            $error("FAIL %s out_fields: got cmd %h data %h want cmd %h data %h",
                   tag, umi_out_cmd, umi_out_data, ef[FW-1 -: CW], ef[DW-1:0]);
        end
        if (exp_id != -2) begin
            obs = (umi_out_valid === 1'b1) ? int'(umi_out_cmd[7:0]) : -1;
            checks++;
            assert (obs === exp_id) else begin
                errors++;
                $error("FAIL %s grant_id: got %0d want %0d", tag, obs, exp_id);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (nreset !== 1'b1) begin
            m_ptr  = 0;
            m_lock = 0;
        end else if (cur_g >= 0 && umi_out_ready === 1'b1) begin
            if (arbmode != UMI_ARB_FIXED) m_ptr = (cur_g + 1) % N;
            m_lock = 0;
        end else if (cur_g >= 0) begin
            m_lock = 1;
            m_lidx = cur_g;
        end else begin
            m_lock = 0;
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag, input int exp_id);
        settle_check(tag, exp_id);
        advance();
    endtask

    // One cycle of random traffic; requesters hold valid until accepted.
    task automatic rand_cycle(input string tag, input bit gen);
        logic [95:0] r96;
        int g;
        if (gen) begin
            for (int i = 0; i < N; i++) begin
                if (umi_in_valid[i] === 1'b0 && $urandom_range(0, 1) == 1) begin
                    r96      = {$urandom, $urandom, $urandom};
                    f_cmd[i] = $urandom;
                    f_dst[i] = {$urandom, $urandom};
                    f_src[i] = {$urandom, $urandom};
                    f_dat[i] = {8'(i), 32'(gen_cnt[i]), r96[87:0]};
                    gen_cnt[i]++;
                    umi_in_valid[i] = 1'b1;
                end
            end
        end
        settle_check(tag, -2);
        g = cur_g;
        if (g >= 0 && umi_out_ready === 1'b1) begin
            checks++;
            assert (umi_out_data[119:88] === 32'(del_cnt[g])) else begin
                errors++;
                $error("FAIL %s seq req%0d: got %0d want %0d", tag, g, umi_out_data[119:88], del_cnt[g]);
            end
            del_cnt[g]++;
        end
        advance();
        if (g >= 0 && umi_out_ready === 1'b1) umi_in_valid[g] = 1'b0;
    endtask

    initial begin
        nreset        = 1'b0;
        arbmode       = UMI_ARB_RR;
        arbmask       = '0;
        umi_in_valid  = '1;
        umi_out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            f_cmd[i]   = 32'hC0DE_0000 | 32'(i);
            f_dst[i]   = {32'hD570_0000, 32'(i)};
            f_src[i]   = {32'h5AC0_0000, 32'(i)};
            f_dat[i]   = {8'(i), 32'h0, 88'h0ABC_DEF0_1234};
            gen_cnt[i] = 0;
            del_cnt[i] = 0;
        end
        #2;
        step("reset", -1);
        step("reset", -1);
        nreset = 1'b1;

        for (int k = 0; k < 8; k++) step("rr_all", k % 4);

        arbmode      = UMI_ARB_FIXED;
        umi_in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) step("fixed", 1);

        arbmode       = UMI_ARB_RR;
        umi_in_valid  = 4'b0100;
        umi_out_ready = 1'b0;
        step("lock_grant", 2);
        umi_in_valid = 4'b0101;
        for (int k = 0; k < 5; k++) step("lock_hold", 2);
        umi_out_ready = 1'b1;
        step("lock_hs", 2);
        umi_in_valid = 4'b0001;
        step("after_lock", 0);

        arbmask      = 4'b0001;
        umi_in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) step("masked_rr", 1 + (k % 3));

        arbmask      = '0;
        umi_in_valid = '0;
        step("idle", -1);

        umi_in_valid  = 4'b1000;
        umi_out_ready = 1'b0;
        step("lock3", 3);
        nreset        = 1'b0;
        umi_in_valid  = 4'b1111;
        step("reset_lock", -1);
        nreset        = 1'b1;
        umi_out_ready = 1'b1;
        step("post_reset", 0);

        umi_in_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) arbmode = 2'($urandom);
            arbmask       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
            umi_out_ready = ($urandom_range(0, 3) != 0);
            rand_cycle("rand", 1'b1);
        end

        arbmask       = '0;
        umi_out_ready = 1'b1;
        for (int c = 0; c < 2 * N; c++) rand_cycle("drain", 1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            assert (del_cnt[i] === gen_cnt[i]) else begin
                errors++;
                $error("FAIL delivered req%0d: got %0d want %0d", i, del_cnt[i], gen_cnt[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
